// File: rtl/nested_int_ctrl.sv
// Nested interrupt controller: edge-captured requests, fixed low-index
// priority, a return-address stack for preemption, and PC override strobes
// for entry and return.
module nested_int_ctrl #(
    parameter int          N_SRC      = 4,
    parameter int          DEPTH      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter int          VEC_STRIDE = 16,
    localparam int         ID_W       = (N_SRC > 2) ? $clog2(N_SRC) : 1,
    localparam int         DW         = $clog2(DEPTH + 1)
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic [N_SRC-1:0]  in_req,
    input  logic [N_SRC-1:0]  in_mask,
    input  logic              in_gie,
    input  logic              in_ack,
    input  logic              in_eret,
    input  logic [31:0]       in_epc,
    output logic              out_irq,
    output logic [ID_W-1:0]   out_id,
    output logic              out_force,
    output logic [31:0]       out_pc,
    output logic              out_flush,
    output logic [N_SRC-1:0]  out_insvc,
    output logic [DW-1:0]     out_depth,
    output logic              out_err
);

    typedef struct packed {
        logic [31:0]     epc;
        logic [ID_W-1:0] id;
    } frame_t;

    frame_t             stk_q [DEPTH];
    logic [N_SRC-1:0]   req_q, pend_q, pend_d, insvc_q;
    logic [DW-1:0]      depth_q;
    logic               force_q, err_q;
    logic [31:0]        pc_q;

    logic               cand_vld, irq, ack_go, eret_go;
    logic [ID_W-1:0]    cand_id, top_id;
    logic [31:0]        top_epc, vec_pc;
    logic [N_SRC-1:0]   cand_oh, top_oh, rise, clr;

    // Pick the lowest-index enabled pending source and peek at the stack top.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend_q[i] && in_mask[i]) begin
                cand_vld = 1'b1;
                cand_id  = ID_W'(i);
            end
        end
        top_id  = '0;
        top_epc = '0;
        if (depth_q != '0) begin
            top_id  = stk_q[depth_q - 1'b1].id;
            top_epc = stk_q[depth_q - 1'b1].epc;
        end
        for (int i = 0; i < N_SRC; i++) begin
            cand_oh[i] = (cand_id == ID_W'(i));
            top_oh[i]  = (top_id == ID_W'(i));
        end
    end

    // Delivery gating, service decisions and next pending set. Only a strictly
    // higher-priority source may preempt, so a source never nests on itself.
    always_comb begin
        irq     = cand_vld && in_gie && (int'(depth_q) < DEPTH) &&
                  ((depth_q == '0) || (cand_id < top_id));
        eret_go = in_eret && (depth_q != '0);
        ack_go  = in_ack && irq && !in_eret;
        rise    = in_req & ~req_q;
        clr     = ack_go ? cand_oh : '0;
        // A fresh edge landing on the clearing cycle must survive the clear.
        pend_d  = (pend_q & ~clr) | rise;
        vec_pc  = VEC_BASE + 32'(cand_id) * 32'(VEC_STRIDE);
    end

    // Edge capture, nesting stack and registered override strobe.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            req_q   <= '0;
            pend_q  <= '0;
            insvc_q <= '0;
            depth_q <= '0;
            force_q <= 1'b0;
            err_q   <= 1'b0;
            pc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else begin
            req_q   <= in_req;
            pend_q  <= pend_d;
            force_q <= ack_go || eret_go;
            if (in_eret && depth_q == '0) err_q <= 1'b1;
            if (ack_go) begin
                stk_q[depth_q] <= '{epc: in_epc, id: cand_id};
                depth_q        <= depth_q + 1'b1;
                insvc_q        <= insvc_q | cand_oh;
                pc_q           <= vec_pc;
            end else if (eret_go) begin
                depth_q <= depth_q - 1'b1;
                insvc_q <= insvc_q & ~top_oh;
                pc_q    <= top_epc;
            end
        end
    end

    assign out_irq   = irq;
    assign out_id    = irq ? cand_id : '0;
    assign out_force = force_q;
    assign out_pc    = pc_q;
    assign out_flush = in_RST | (in_ack & irq) | in_eret;
    assign out_insvc = insvc_q;
    assign out_depth = depth_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Directed vector bench for nested_int_ctrl (N_SRC=4, DEPTH=3).
module tb_nested_int_ctrl;

    logic        clk, rst;
    logic [3:0]  req, mask;
    logic        gie, ack, eret;
    logic [31:0] epc;
    logic        irq, frc, flush, err;
    logic [1:0]  id, dep;
    logic [31:0] pc;
    logic [3:0]  ins;

    nested_int_ctrl dut (
        .in_CLK(clk), .in_RST(rst), .in_req(req), .in_mask(mask),
        .in_gie(gie), .in_ack(ack), .in_eret(eret), .in_epc(epc),
        .out_irq(irq), .out_id(id), .out_force(frc), .out_pc(pc),
        .out_flush(flush), .out_insvc(ins), .out_depth(dep), .out_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req, mask;
        logic        gie, ack, eret;
        logic [31:0] epc;
        logic        irq;
        logic [1:0]  id;
        logic        frc;
        logic [31:0] pc;
        logic [1:0]  dep;
        logic [3:0]  ins;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic [3:0] r, m, input logic g, a, e,
                       input logic [31:0] ep, input logic xi, input logic [1:0] xid,
                       input logic xf, input logic [31:0] xpc,
                       input logic [1:0] xd, input logic [3:0] xins);
        vec_t v;
        v.req = r; v.mask = m; v.gie = g; v.ack = a; v.eret = e; v.epc = ep;
        v.irq = xi; v.id = xid; v.frc = xf; v.pc = xpc; v.dep = xd; v.ins = xins;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic xi, input logic [1:0] xid,
                           input logic xf, input logic [31:0] xpc, input logic [1:0] xd,
                           input logic [3:0] xins, input logic xfl, input logic xe);
        n_vec++;
        chk({tag, ".irq"},   32'(irq),   32'(xi));
        chk({tag, ".id"},    32'(id),    32'(xid));
        chk({tag, ".force"}, 32'(frc),   32'(xf));
        chk({tag, ".pc"},    pc,         xpc);
        chk({tag, ".depth"}, 32'(dep),   32'(xd));
        chk({tag, ".insvc"}, 32'(ins),   32'(xins));
        chk({tag, ".flush"}, 32'(flush), 32'(xfl));
        chk({tag, ".err"},   32'(err),   32'(xe));
    endtask

    initial begin
        // req mask gie ack eret epc | irq id force pc depth insvc
        add(4'h0,4'hF,1,0,0,32'h0,   0,0,0,32'h0,  0,4'h0); // 0 idle
        add(4'h4,4'hF,1,0,0,32'h0,   0,0,0,32'h0,  0,4'h0); // 1 edge src2
        add(4'h4,4'hF,1,0,0,32'h0,   1,2,0,32'h0,  0,4'h0); // 2 offered
        add(4'h4,4'hF,1,1,0,32'h100, 1,2,0,32'h0,  0,4'h0); // 3 ack
        add(4'h1,4'hF,1,0,0,32'h0,   0,0,1,32'h820,1,4'h4); // 4 vector 0x820, edge src0
        add(4'h1,4'hF,1,0,0,32'h0,   1,0,0,32'h820,1,4'h4); // 5 preempt offered
        add(4'h1,4'hF,1,1,0,32'h830, 1,0,0,32'h820,1,4'h4); // 6 ack nested
        add(4'h1,4'hF,1,0,0,32'h0,   0,0,1,32'h800,2,4'h5); // 7 vector 0x800
        add(4'h1,4'hF,1,0,1,32'h0,   0,0,0,32'h800,2,4'h5); // 8 eret
        add(4'h1,4'hF,1,0,1,32'h0,   0,0,1,32'h830,1,4'h4); // 9 return 0x830, eret
        add(4'h0,4'hF,1,0,0,32'h0,   0,0,1,32'h100,0,4'h0); // 10 return 0x100
        add(4'h2,4'hF,1,0,0,32'h0,   0,0,0,32'h100,0,4'h0); // 11 edge src1
        add(4'h2,4'hF,1,1,0,32'h200, 1,1,0,32'h100,0,4'h0); // 12 ack src1
        add(4'h8,4'hF,1,0,0,32'h0,   0,0,1,32'h810,1,4'h2); // 13 edge src3
        add(4'h8,4'hF,1,0,0,32'h0,   0,0,0,32'h810,1,4'h2); // 14 lower prio blocked
        add(4'h8,4'hF,1,0,1,32'h0,   0,0,0,32'h810,1,4'h2); // 15 eret
        add(4'h8,4'hF,1,0,0,32'h0,   1,3,1,32'h200,0,4'h0); // 16 src3 now offered
        add(4'h8,4'h7,1,0,0,32'h0,   0,0,0,32'h200,0,4'h0); // 17 masked, still pending
        add(4'h8,4'hF,0,0,0,32'h0,   0,0,0,32'h200,0,4'h0); // 18 gie off
        add(4'h8,4'hF,1,0,0,32'h0,   1,3,0,32'h200,0,4'h0); // 19 re-offered
        add(4'h8,4'hF,1,1,0,32'h300, 1,3,0,32'h200,0,4'h0); // 20 ack src3
        add(4'h4,4'hF,1,0,0,32'h0,   0,0,1,32'h830,1,4'h8); // 21 edge src2
        add(4'h4,4'hF,1,1,0,32'h310, 1,2,0,32'h830,1,4'h8); // 22 ack src2
        add(4'h2,4'hF,1,0,0,32'h0,   0,0,1,32'h820,2,4'hC); // 23 edge src1
        add(4'h2,4'hF,1,1,0,32'h320, 1,1,0,32'h820,2,4'hC); // 24 ack src1
        add(4'h1,4'hF,1,0,0,32'h0,   0,0,1,32'h810,3,4'hE); // 25 edge src0
        add(4'h1,4'hF,1,0,0,32'h0,   0,0,0,32'h810,3,4'hE); // 26 full stack blocks
        add(4'h1,4'hF,1,1,0,32'h0,   0,0,0,32'h810,3,4'hE); // 27 ack without irq
        add(4'h1,4'hF,1,0,0,32'h0,   0,0,0,32'h810,3,4'hE); // 28 no change
        add(4'h1,4'hF,1,0,1,32'h0,   0,0,0,32'h810,3,4'hE); // 29 eret
        add(4'h1,4'hF,1,0,0,32'h0,   1,0,1,32'h320,2,4'hC); // 30 src0 offered
        add(4'h1,4'hF,1,1,1,32'h999, 1,0,0,32'h320,2,4'hC); // 31 ack+eret
        add(4'h0,4'hF,1,0,0,32'h0,   1,0,1,32'h310,1,4'h8); // 32 eret won, irq again
        add(4'h1,4'hF,1,1,0,32'h400, 1,0,0,32'h310,1,4'h8); // 33 ack with new edge
        add(4'h1,4'hF,1,0,0,32'h0,   0,0,1,32'h800,2,4'h9); // 34 no self-preempt
        add(4'h1,4'hF,1,0,1,32'h0,   0,0,0,32'h800,2,4'h9); // 35 eret
        add(4'h1,4'hF,1,0,0,32'h0,   1,0,1,32'h400,1,4'h8); // 36 edge survived clear
        add(4'h1,4'hF,1,1,0,32'h500, 1,0,0,32'h400,1,4'h8); // 37 ack src0
        add(4'h3,4'hF,1,0,0,32'h0,   0,0,1,32'h800,2,4'h9); // 38 edge src1 pending

        rst = 1'b1; req = '0; mask = 4'hF; gie = 1'b1; ack = 1'b0; eret = 1'b0; epc = '0;
        #2;
        chk_all("reset", 0, 0, 0, 32'h0, 0, 4'h0, 1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[k]) begin
            @(posedge clk);
            #1;
            req = tbl[k].req; mask = tbl[k].mask; gie = tbl[k].gie;
            ack = tbl[k].ack; eret = tbl[k].eret; epc = tbl[k].epc;
            @(negedge clk);
            chk_all($sformatf("v%0d", k), tbl[k].irq, tbl[k].id, tbl[k].frc, tbl[k].pc,
                    tbl[k].dep, tbl[k].ins, (tbl[k].ack & tbl[k].irq) | tbl[k].eret, 1'b0);
        end

        // Asynchronous reset at depth 2 with src1 pending.
        @(posedge clk);
        #1 req = '0; ack = 1'b0; eret = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all("rst_async", 0, 0, 0, 32'h0, 0, 4'h0, 1, 0);
        @(negedge clk);
        chk_all("rst_hold", 0, 0, 0, 32'h0, 0, 4'h0, 1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all("rst_rel1", 0, 0, 0, 32'h0, 0, 4'h0, 0, 0);
        @(negedge clk);
        chk_all("rst_rel2", 0, 0, 0, 32'h0, 0, 4'h0, 0, 0);

        // Eret with nothing in service: sticky error, no override.
        @(posedge clk);
        #1 eret = 1'b1;
        @(negedge clk);
        chk_all("eret0", 0, 0, 0, 32'h0, 0, 4'h0, 1, 0);
        @(posedge clk);
        #1 eret = 1'b0;
        @(negedge clk);
        chk_all("err_set", 0, 0, 0, 32'h0, 0, 4'h0, 0, 1);
        @(negedge clk);
        chk_all("err_sticky", 0, 0, 0, 32'h0, 0, 4'h0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
